// File: rtl/video_frame_ctrl_if.sv
// rtl/video_frame_ctrl_if.sv - video stream bundle with SOF (tuser) and EOL (tlast) markers
interface video_frame_ctrl_if #(
    parameter int DATA_W = 24
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/video_frame_ctrl.sv
// rtl/video_frame_ctrl.sv - frame-aligned gate with geometry checks and one registered output stage
module video_frame_ctrl #(
    parameter int DATA_W = 24,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CNT_W  = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    video_frame_ctrl_if.slave     s_axis,
    video_frame_ctrl_if.master    m_axis,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_line,
    output logic                  err_sof,
    output logic [15:0]           frame_count
);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, PASS} state_t;

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(HEIGHT - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   x, x_n, y, y_n, x_cur, y_cur;
    logic               slot_free, s_ready, fwd;
    logic               done_n, el_n, es_n;
    logic               out_valid, out_user, out_last;
    logic [DATA_W-1:0]  out_data;

    assign slot_free     = !out_valid || m_axis.tready;
    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_data;
    assign m_axis.tuser  = out_user;
    assign m_axis.tlast  = out_last;
    assign busy          = (state == PASS);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        x_cur   = x;
        y_cur   = y;
        s_ready = 1'b1;
        fwd     = 1'b0;
        done_n  = 1'b0;
        el_n    = 1'b0;
        es_n    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_n = WAIT_SOF;
            end
            WAIT_SOF: begin
                // Only a SOF beat is subject to back-pressure; everything else is flushed.
                if (!enable) begin
                    state_n = IDLE;
                end else if (s_axis.tuser) begin
                    s_ready = slot_free;
                    fwd     = s_axis.tvalid && slot_free;
                end
            end
            PASS: begin
                s_ready = slot_free;
                fwd     = s_axis.tvalid && slot_free;
            end
            default: state_n = IDLE;
        endcase

        if (fwd) begin
            // A SOF beat always restarts geometry at (0,0) before the line check.
            es_n  = (state == PASS) && s_axis.tuser;
            x_cur = s_axis.tuser ? '0 : x;
            y_cur = s_axis.tuser ? '0 : y;
            if (s_axis.tlast != (x_cur == X_LAST)) begin
                el_n    = 1'b1;
                x_n     = '0;
                y_n     = '0;
                state_n = enable ? WAIT_SOF : IDLE;
            end else if (s_axis.tlast) begin
                x_n = '0;
                if (y_cur == Y_LAST) begin
                    y_n     = '0;
                    done_n  = 1'b1;
                    state_n = enable ? WAIT_SOF : IDLE;
                end else begin
                    y_n     = y_cur + CNT_W'(1);
                    state_n = PASS;
                end
            end else begin
                x_n     = x_cur + CNT_W'(1);
                y_n     = y_cur;
                state_n = PASS;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x           <= '0;
            y           <= '0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_sof     <= 1'b0;
            frame_count <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_user    <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            x          <= x_n;
            y          <= y_n;
            frame_done <= done_n;
            err_line   <= el_n;
            err_sof    <= es_n;
            if (done_n) frame_count <= frame_count + 16'd1;
            if (fwd) begin
                out_valid <= 1'b1;
                out_data  <= s_axis.tdata;
                out_user  <= s_axis.tuser;
                out_last  <= s_axis.tlast;
            end else if (m_axis.tready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
